// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock true dual-port RAM, read-first on both ports. HIGH_PERFORMANCE adds a
// port-B output register (two-cycle read latency); LOW_LATENCY reads in one cycle.
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int unsigned RAM_WIDTH       = 18,
  parameter int unsigned RAM_DEPTH       = 1024,
  parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic                         clka,
  input  logic                         ena,
  input  logic                         wea,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         enb,
  input  logic                         web,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dinb,
  input  logic                         rstb,
  input  logic                         regceb,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_b;

  always_ff @(posedge clka) begin
    if (ena && wea) mem[addra] <= dina;
    if (enb && web) mem[addrb] <= dinb;
  end

  // Non-blocking read of the array returns the pre-write word on a same-address collision.
  always_ff @(posedge clka) begin
    if (enb) ram_data_b <= mem[addrb];
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
    assign doutb = ram_data_b;
  end else begin : g_high_performance
    logic [RAM_WIDTH-1:0] doutb_q;
    always_ff @(posedge clka) begin
      if (rstb)        doutb_q <= '0;
      else if (regceb) doutb_q <= ram_data_b;
    end
    assign doutb = doutb_q;
  end

endmodule

// File: rtl/pingpong_playback_buffer.sv
// Ping-pong frame buffer: a frame is written into one bank while the other bank is
// played back one sample per HOLD ticks; committing the last sample swaps the banks.
module pingpong_playback_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2200,
  parameter int unsigned HOLD  = 1,
  parameter int unsigned LOOP  = 0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     wr_valid_in,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_in,
  input  logic [WIDTH-1:0]         wr_data_in,
  input  logic                     wr_last_in,
  input  logic                     tick_in,
  output logic [WIDTH-1:0]         rd_data_out,
  output logic                     rd_valid_out,
  output logic                     bank_out,
  output logic                     playing_out,
  output logic [$clog2(DEPTH):0]   frame_len_out,
  output logic                     overrun_out,
  output logic                     underrun_out
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned PAW = $clog2(2 * DEPTH);
  localparam int unsigned HW  = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [LW-1:0]  DepthL  = LW'(DEPTH);
  localparam logic [HW-1:0]  HoldMax = HW'(HOLD - 1);
  localparam logic [PAW-1:0] BankOfs = PAW'(DEPTH);
  localparam bit             Loop    = (LOOP != 0);

  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic          playing_q, playing_d, finished_q, finished_d;
  logic          wrapped_q, wrapped_d, urun_done_q, urun_done_d;
  logic          overrun_q, overrun_d, underrun_q, underrun_d;
  logic [LW-1:0] frame_len_q, frame_len_d, rd_addr_q, rd_addr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    vld_q, vld_d, zero_q, zero_d;

  logic           wr_ok, commit, active;
  logic [PAW-1:0] wr_phys, rd_phys;
  logic [WIDTH-1:0] ram_dout;

  assign wr_ok   = wr_valid_in && ({1'b0, wr_addr_in} < DepthL);
  assign commit  = wr_ok && wr_last_in;
  assign active  = playing_q && !finished_q;
  assign wr_phys = PAW'(wr_addr_in) + (wr_bank_q ? BankOfs : '0);
  assign rd_phys = PAW'(rd_addr_q) + (rd_bank_q ? BankOfs : '0);

  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    playing_d   = playing_q;
    finished_d  = finished_q;
    wrapped_d   = wrapped_q;
    urun_done_d = urun_done_q;
    frame_len_d = frame_len_q;
    rd_addr_d   = rd_addr_q;
    hold_d      = hold_q;
    overrun_d   = 1'b0;
    underrun_d  = 1'b0;
    // zero_q tags ticks whose sample must read as 0 when it leaves the pipeline.
    vld_d       = {vld_q[0], tick_in};
    zero_d      = {zero_q[0], !active};

    if (tick_in && active) begin
      if (hold_q == HoldMax) begin
        hold_d    = '0;
        rd_addr_d = rd_addr_q + LW'(1);
        if (rd_addr_q + LW'(1) == frame_len_q) begin
          if (Loop) begin
            rd_addr_d = '0;
            wrapped_d = 1'b1;
          end else begin
            finished_d = 1'b1;
          end
        end
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end

    if (tick_in && playing_q && finished_q && !urun_done_q) begin
      underrun_d  = 1'b1;
      urun_done_d = 1'b1;
    end

    // The swap overrides the tick update above, so a coincident tick used the old frame.
    if (commit) begin
      overrun_d   = playing_q && (Loop ? !wrapped_q : !finished_q);
      rd_bank_d   = wr_bank_q;
      wr_bank_d   = !wr_bank_q;
      frame_len_d = {1'b0, wr_addr_in} + LW'(1);
      rd_addr_d   = '0;
      hold_d      = '0;
      playing_d   = 1'b1;
      finished_d  = 1'b0;
      wrapped_d   = 1'b0;
      urun_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      playing_q   <= 1'b0;
      finished_q  <= 1'b0;
      wrapped_q   <= 1'b0;
      urun_done_q <= 1'b0;
      frame_len_q <= '0;
      rd_addr_q   <= '0;
      hold_q      <= '0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      vld_q       <= '0;
      zero_q      <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      playing_q   <= playing_d;
      finished_q  <= finished_d;
      wrapped_q   <= wrapped_d;
      urun_done_q <= urun_done_d;
      frame_len_q <= frame_len_d;
      rd_addr_q   <= rd_addr_d;
      hold_q      <= hold_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      vld_q       <= vld_d;
      zero_q      <= zero_d;
    end
  end

  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH      (WIDTH),
    .RAM_DEPTH      (2 * DEPTH),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE")
  ) u_ram (
    .clka  (clk_in),
    .ena   (1'b1),
    .wea   (wr_ok),
    .addra (wr_phys),
    .dina  (wr_data_in),
    .enb   (1'b1),
    .web   (1'b0),
    .addrb (rd_phys),
    .dinb  ({WIDTH{1'b0}}),
    .rstb  (1'b0),
    .regceb(1'b1),
    .doutb (ram_dout)
  );

  // Gating on the valid stage keeps the data output at 0 through an asynchronous reset.
  assign rd_data_out   = (vld_q[1] && !zero_q[1]) ? ram_dout : '0;
  assign rd_valid_out  = vld_q[1];
  assign bank_out      = rd_bank_q;
  assign playing_out   = playing_q;
  assign frame_len_out = frame_len_q;
  assign overrun_out   = overrun_q;
  assign underrun_out  = underrun_q;

endmodule

// File: tb/tb_pingpong_playback_buffer.sv
// Bench for pingpong_playback_buffer: three instances (HOLD=1, HOLD=3, LOOP=1) share stimulus;
// each scenario checks one instance against expected samples queued at tick time.
module tb_pingpong_playback_buffer;
  localparam int unsigned W = 32;
  typedef struct { logic [W-1:0] data; int cyc; } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic wr_valid_in = 1'b0;
  logic wr_last_in = 1'b0;
  logic tick_in = 1'b0;
  logic [2:0] wr_addr_in = '0;
  logic [W-1:0] wr_data_in = '0;

  logic [W-1:0] rd_data [3];
  logic         rd_valid [3];
  logic         bank [3];
  logic         playing [3];
  logic         overrun [3];
  logic         underrun [3];
  logic [3:0]   flen [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sel = 0;
  exp_t exp_q[$];

  logic [W-1:0] obs_data;
  logic         obs_valid, obs_bank, obs_playing, obs_overrun, obs_urun;
  logic [3:0]   obs_len;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always_comb begin
    obs_data    = rd_data[sel];
    obs_valid   = rd_valid[sel];
    obs_bank    = bank[sel];
    obs_playing = playing[sel];
    obs_overrun = overrun[sel];
    obs_urun    = underrun[sel];
    obs_len     = flen[sel];
  end

  pingpong_playback_buffer #(.WIDTH(W), .DEPTH(8), .HOLD(1), .LOOP(0)) u_dut0 (
    .clk_in(clk_in), .rst_in(rst_in), .wr_valid_in(wr_valid_in), .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in), .wr_last_in(wr_last_in), .tick_in(tick_in),
    .rd_data_out(rd_data[0]), .rd_valid_out(rd_valid[0]), .bank_out(bank[0]),
    .playing_out(playing[0]), .frame_len_out(flen[0]), .overrun_out(overrun[0]),
    .underrun_out(underrun[0]));

  pingpong_playback_buffer #(.WIDTH(W), .DEPTH(8), .HOLD(3), .LOOP(0)) u_dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .wr_valid_in(wr_valid_in), .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in), .wr_last_in(wr_last_in), .tick_in(tick_in),
    .rd_data_out(rd_data[1]), .rd_valid_out(rd_valid[1]), .bank_out(bank[1]),
    .playing_out(playing[1]), .frame_len_out(flen[1]), .overrun_out(overrun[1]),
    .underrun_out(underrun[1]));

  pingpong_playback_buffer #(.WIDTH(W), .DEPTH(6), .HOLD(1), .LOOP(1)) u_dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .wr_valid_in(wr_valid_in), .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in), .wr_last_in(wr_last_in), .tick_in(tick_in),
    .rd_data_out(rd_data[2]), .rd_valid_out(rd_valid[2]), .bank_out(bank[2]),
    .playing_out(playing[2]), .frame_len_out(flen[2]), .overrun_out(overrun[2]),
    .underrun_out(underrun[2]));

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_word(input logic [2:0] addr, input logic [W-1:0] data, input logic last);
    wr_valid_in = 1'b1;
    wr_addr_in  = addr;
    wr_data_in  = data;
    wr_last_in  = last;
    step();
    wr_valid_in = 1'b0;
    wr_last_in  = 1'b0;
  endtask

  task automatic do_reset();
    tick_in = 1'b0;
    rst_in  = 1'b0;
    step();
    step();
    rst_in = 1'b1;
    step();
    exp_q.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    int n_seen = 0;
    sel = 0;
    #1 rst_in = 1'b0;
    #2;
    checks++;
    if ({obs_valid, obs_playing, obs_bank, obs_overrun, obs_urun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {obs_valid, obs_playing, obs_bank, obs_overrun, obs_urun});
    end
    checks++;
    if (obs_data !== '0 || obs_len !== 4'd0) begin
      errors++;
      $display("FAIL reset_data_len got data %0d len %0d want 0 0", obs_data, obs_len);
    end
    step();
    step();
    rst_in = 1'b1;
    step();
    for (int c = 0; c < 10; c++) begin
      tick_in = (c == 0 || c == 3 || c == 4);
      if (tick_in) exp_q.push_back('{data: '0, cyc: cyc});
      @(negedge clk_in);
      if (obs_valid) begin
        n_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL idle_extra_valid got data %0d want no output", obs_data);
        end else begin
          e = exp_q.pop_front();
          if (obs_data !== e.data || cyc - e.cyc != 2) begin
            errors++;
            $display("FAIL idle_sample got %0d lat %0d want %0d lat 2", obs_data, cyc - e.cyc, e.data);
          end
        end
      end
      step();
    end
    tick_in = 1'b0;
    checks++;
    if (n_seen != 3 || obs_playing !== 1'b0) begin
      errors++;
      $display("FAIL idle_count got %0d pulses playing %b want 3 pulses playing 0", n_seen, obs_playing);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int urun = 0;
    logic [W-1:0] vals [6] = '{1, 2, 3, 4, 5, 0};
    sel = 0;
    for (int i = 0; i < 4; i++) write_word(3'(i), W'(i + 1), 1'b0);
    checks++;
    if (obs_playing !== 1'b0) begin
      errors++;
      $display("FAIL basic_precommit_playing got %b want 0", obs_playing);
    end
    write_word(3'd4, W'(5), 1'b1);
    checks++;
    if (obs_len !== 4'd5 || obs_bank !== 1'b0 || obs_playing !== 1'b1 || obs_overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_commit got len %0d bank %b play %b ovr %b want 5 0 1 0",
               obs_len, obs_bank, obs_playing, obs_overrun);
    end
    for (int c = 0; c < 9; c++) begin
      tick_in = (c < 6);
      if (tick_in) exp_q.push_back('{data: vals[c], cyc: cyc});
      @(negedge clk_in);
      if (obs_urun) urun++;
      if (obs_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL basic_extra_valid got data %0d want no output", obs_data);
        end else begin
          e = exp_q.pop_front();
          if (obs_data !== e.data || cyc - e.cyc != 2) begin
            errors++;
            $display("FAIL basic_sample got %0d lat %0d want %0d lat 2", obs_data, cyc - e.cyc, e.data);
          end
        end
      end
      step();
    end
    tick_in = 1'b0;
    checks++;
    if (exp_q.size() != 0 || urun != 1) begin
      errors++;
      $display("FAIL basic_drain got %0d pending %0d underruns want 0 1", exp_q.size(), urun);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int urun = 0;
    logic [W-1:0] vals [7] = '{10, 10, 10, 20, 20, 20, 0};
    sel = 1;
    do_reset();
    write_word(3'd0, W'(10), 1'b0);
    write_word(3'd1, W'(20), 1'b1);
    checks++;
    if (obs_len !== 4'd2) begin
      errors++;
      $display("FAIL hold_len got %0d want 2", obs_len);
    end
    for (int c = 0; c < 10; c++) begin
      tick_in = (c < 7);
      if (tick_in) exp_q.push_back('{data: vals[c], cyc: cyc});
      @(negedge clk_in);
      if (obs_urun) urun++;
      if (obs_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL hold_extra_valid got data %0d want no output", obs_data);
        end else begin
          e = exp_q.pop_front();
          if (obs_data !== e.data || cyc - e.cyc != 2) begin
            errors++;
            $display("FAIL hold_sample got %0d lat %0d want %0d lat 2", obs_data, cyc - e.cyc, e.data);
          end
        end
      end
      step();
    end
    tick_in = 1'b0;
    checks++;
    if (exp_q.size() != 0 || urun != 1) begin
      errors++;
      $display("FAIL hold_drain got %0d pending %0d underruns want 0 1", exp_q.size(), urun);
    end
  endtask

  task automatic test_loop();
    exp_t e;
    int urun = 0;
    logic [W-1:0] vals [7] = '{7, 8, 9, 7, 8, 9, 7};
    sel = 2;
    do_reset();
    write_word(3'd6, W'(55), 1'b1);
    checks++;
    if (obs_playing !== 1'b0 || obs_len !== 4'd0 || obs_bank !== 1'b0) begin
      errors++;
      $display("FAIL loop_ignored_write got play %b len %0d bank %b want 0 0 0",
               obs_playing, obs_len, obs_bank);
    end
    write_word(3'd0, W'(7), 1'b0);
    write_word(3'd1, W'(8), 1'b0);
    write_word(3'd2, W'(9), 1'b1);
    checks++;
    if (obs_len !== 4'd3 || obs_playing !== 1'b1) begin
      errors++;
      $display("FAIL loop_commit got len %0d play %b want 3 1", obs_len, obs_playing);
    end
    for (int c = 0; c < 10; c++) begin
      tick_in = (c < 7);
      if (tick_in) exp_q.push_back('{data: vals[c], cyc: cyc});
      @(negedge clk_in);
      if (obs_urun) urun++;
      if (obs_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL loop_extra_valid got data %0d want no output", obs_data);
        end else begin
          e = exp_q.pop_front();
          if (obs_data !== e.data || cyc - e.cyc != 2) begin
            errors++;
            $display("FAIL loop_sample got %0d lat %0d want %0d lat 2", obs_data, cyc - e.cyc, e.data);
          end
        end
      end
      step();
    end
    tick_in = 1'b0;
    checks++;
    if (exp_q.size() != 0 || urun != 0) begin
      errors++;
      $display("FAIL loop_drain got %0d pending %0d underruns want 0 0", exp_q.size(), urun);
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    sel = 0;
    do_reset();
    for (int i = 0; i < 5; i++) write_word(3'(i), W'(i + 1), (i == 4));
    write_word(3'd0, W'(100), 1'b0);
    write_word(3'd1, W'(200), 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick_in     = (c == 0 || c == 1 || c == 2 || c == 3);
      wr_valid_in = (c == 2);
      wr_last_in  = (c == 2);
      wr_addr_in  = 3'd2;
      wr_data_in  = W'(300);
      if (c == 0) exp_q.push_back('{data: W'(1), cyc: cyc});
      if (c == 1) exp_q.push_back('{data: W'(2), cyc: cyc});
      if (c == 2) exp_q.push_back('{data: W'(3), cyc: cyc});
      if (c == 3) begin
        exp_q.push_back('{data: W'(100), cyc: cyc});
        checks++;
        if (obs_overrun !== 1'b1 || obs_bank !== 1'b1 || obs_len !== 4'd3) begin
          errors++;
          $display("FAIL overrun_swap got ovr %b bank %b len %0d want 1 1 3",
                   obs_overrun, obs_bank, obs_len);
        end
      end
      if (c == 4) begin
        checks++;
        if (obs_overrun !== 1'b0) begin
          errors++;
          $display("FAIL overrun_pulse_width got %b want 0", obs_overrun);
        end
      end
      @(negedge clk_in);
      if (obs_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL overrun_extra_valid got data %0d want no output", obs_data);
        end else begin
          e = exp_q.pop_front();
          if (obs_data !== e.data || cyc - e.cyc != 2) begin
            errors++;
            $display("FAIL overrun_sample got %0d lat %0d want %0d lat 2", obs_data, cyc - e.cyc, e.data);
          end
        end
      end
      step();
    end
    tick_in = 1'b0;
    wr_valid_in = 1'b0;
    wr_last_in = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n_valid = 0;
    sel = 0;
    do_reset();
    for (int i = 0; i < 5; i++) write_word(3'(i), W'(i + 1), (i == 4));
    write_word(3'd0, W'(100), 1'b1);
    tick_in = 1'b1;
    step();
    step();
    tick_in = 1'b0;
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== W'(100) || obs_bank !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_reset got valid %b data %0d bank %b want 1 100 1",
               obs_valid, obs_data, obs_bank);
    end
    #2 rst_in = 1'b0;
    #1;
    checks++;
    if ({obs_valid, obs_playing, obs_bank, obs_overrun, obs_urun} !== 5'b0 ||
        obs_data !== '0 || obs_len !== 4'd0) begin
      errors++;
      $display("FAIL mid_async_clear got flags %b data %0d len %0d want 00000 0 0",
               {obs_valid, obs_playing, obs_bank, obs_overrun, obs_urun}, obs_data, obs_len);
    end
    step();
    rst_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      if (obs_valid) n_valid++;
      step();
    end
    checks++;
    if (n_valid != 0) begin
      errors++;
      $display("FAIL mid_no_valid_after_reset got %0d pulses want 0", n_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_loop();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
